// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised register file with clear engine; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_param #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            clr_req,
  output logic            busy,
  output logic            clr_done,
  output logic            wr_drop
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [AW-1:0] PTR_FIRST = AW'(1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] regs [DEPTH];
  logic            wr_req;
  logic            write_ok;

  assign wr_req   = we && (rd != '0);
  assign write_ok = (state == IDLE) && wr_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= PTR_FIRST;
    end else begin
      state <= state_nxt;
      if (state == IDLE && clr_req) begin
        ptr <= PTR_FIRST;
      end else if (state == CLEAR && ptr != PTR_LAST) begin
        ptr <= ptr + PTR_FIRST;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (ptr == PTR_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    clr_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= busy && wr_req;
    end
  end

  // Entry 0 is never written; the read muxes below mask it to zero.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[ptr] <= '0;
    end else if (!rst && write_ok) begin
      regs[rd] <= wd;
    end
  end

  // Cleared and not-yet-cleared entries both read as zero while busy.
  always_comb begin
    rd1 = '0;
    if (!busy && rs1 != '0) begin
      rd1 = regs[rs1];
`ifdef REGFILE_BYPASS_EN
      if (wr_req && rd == rs1) rd1 = wd;
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if (!busy && rs2 != '0) begin
      rd2 = regs[rs2];
`ifdef REGFILE_BYPASS_EN
      if (wr_req && rd == rs2) rd2 = wd;
`endif
    end
  end

endmodule
